banco_reg_param: RTL and testbench

Parametrised register bank for the single-cycle processor datapath: NREG general registers plus the WORK accumulator, one write port, two registered read ports with write-through bypass, and a shadow bank with a multi-cycle save/restore sequencer for context switches. It replaces the fixed 8-bit, 4+1-register bank and takes decoded addresses from the control unit instead of raw instruction fields.

---
 rtl/banco_reg_param.sv | 183 ++++++++++++++++++
 tb/tb_banco_reg_param.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/banco_reg_param.sv
// banco_reg_param: register bank with NREG general registers plus WORK,
// one write port, two registered read ports with write-through bypass,
// and a shadow bank filled/emptied by a one-copy-per-cycle sequencer.
module banco_reg_param #(
  parameter int DATA_W = 8,
  parameter int NREG   = 4,
  parameter int ADDR_W = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  output logic [DATA_W-1:0] work_q,
  input  logic [1:0]        ctx_cmd,
  output logic              ctx_busy,
  output logic              ctx_done
);

  // WORK lives just above the general registers; it is also the last copy index
  localparam logic [ADDR_W-1:0] LP_WORK = ADDR_W'(NREG);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SAVE,
    ST_RESTORE
  } state_t;

  state_t            r_state;
  state_t            w_nextState;
  logic [ADDR_W-1:0] r_idx;
  logic [DATA_W-1:0] r_regs   [0:NREG];
  logic [DATA_W-1:0] r_shadow [0:NREG];
  logic [DATA_W-1:0] r_rdata1;
  logic [DATA_W-1:0] r_rdata2;
  logic              r_done;

  logic              w_writeOk;
  logic              w_saveStep;
  logic              w_restoreStep;
  logic              w_lastStep;
  logic [DATA_W-1:0] w_arr1;
  logic [DATA_W-1:0] w_arr2;

  // Writes are only honoured when idle and aimed at an existing register
  assign w_writeOk = we && (r_state == ST_IDLE) && (waddr <= LP_WORK);

  // Sequencer state register
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Sequencer next state: accept save/restore when idle, finish after copying WORK
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE: begin
        if (ctx_cmd == 2'b01) begin
          w_nextState = ST_SAVE;
        end else if (ctx_cmd == 2'b10) begin
          w_nextState = ST_RESTORE;
        end
      end
      ST_SAVE, ST_RESTORE: begin
        if (r_idx == LP_WORK) begin
          w_nextState = ST_IDLE;
        end
      end
      default: w_nextState = ST_IDLE;
    endcase
  end

  // Sequencer outputs: busy flag and per-cycle copy strobes
  always_comb begin
    ctx_busy      = 1'b0;
    w_saveStep    = 1'b0;
    w_restoreStep = 1'b0;
    case (r_state)
      ST_SAVE: begin
        ctx_busy   = 1'b1;
        w_saveStep = 1'b1;
      end
      ST_RESTORE: begin
        ctx_busy      = 1'b1;
        w_restoreStep = 1'b1;
      end
      default: ;
    endcase
  end

  assign w_lastStep = ctx_busy && (r_idx == LP_WORK);

  // Copy index walks 0..NREG while busy and parks at 0 otherwise
  always_ff @(posedge clock) begin
    if (reset) begin
      r_idx <= '0;
    end else if (!ctx_busy || w_lastStep) begin
      r_idx <= '0;
    end else begin
      r_idx <= r_idx + 1'b1;
    end
  end

  // Done pulses for one cycle after the final copy; a reset abort never pulses
  always_ff @(posedge clock) begin
    if (reset) begin
      r_done <= 1'b0;
    end else begin
      r_done <= w_lastStep;
    end
  end

  // Live registers: port writes when idle, shadow copies during restore
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i <= NREG; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      for (int i = 0; i <= NREG; i++) begin
        if (w_writeOk && (waddr == ADDR_W'(i))) begin
          r_regs[i] <= wdata;
        end else if (w_restoreStep && (r_idx == ADDR_W'(i))) begin
          r_regs[i] <= r_shadow[i];
        end
      end
    end
  end

  // Shadow registers: filled one entry per cycle during save
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i <= NREG; i++) begin
        r_shadow[i] <= '0;
      end
    end else begin
      for (int i = 0; i <= NREG; i++) begin
        if (w_saveStep && (r_idx == ADDR_W'(i))) begin
          r_shadow[i] <= r_regs[i];
        end
      end
    end
  end

  // Array read muxes; addresses beyond WORK read as zero
  always_comb begin
    w_arr1 = '0;
    w_arr2 = '0;
    for (int i = 0; i <= NREG; i++) begin
      if (raddr1 == ADDR_W'(i)) begin
        w_arr1 = r_regs[i];
      end
      if (raddr2 == ADDR_W'(i)) begin
        w_arr2 = r_regs[i];
      end
    end
  end

  // Registered read ports; a same-edge port write bypasses the array
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rdata1 <= '0;
      r_rdata2 <= '0;
    end else begin
      r_rdata1 <= (w_writeOk && (waddr == raddr1)) ? wdata : w_arr1;
      r_rdata2 <= (w_writeOk && (waddr == raddr2)) ? wdata : w_arr2;
    end
  end

  assign rdata1   = r_rdata1;
  assign rdata2   = r_rdata2;
  assign work_q   = r_regs[NREG];
  assign ctx_done = r_done;

endmodule

// File: tb/tb_banco_reg_param.sv
// Testbench for banco_reg_param: directed context-switch scenarios followed
// by random traffic, all compared cycle by cycle against a reference model.
module tb_banco_reg_param;

  localparam int DATA_W = 8;
  localparam int NREG   = 4;
  localparam int ADDR_W = 3;

  logic              clock;
  logic              reset;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic [ADDR_W-1:0] raddr1;
  logic [ADDR_W-1:0] raddr2;
  logic [DATA_W-1:0] rdata1;
  logic [DATA_W-1:0] rdata2;
  logic [DATA_W-1:0] work_q;
  logic [1:0]        ctx_cmd;
  logic              ctx_busy;
  logic              ctx_done;

  banco_reg_param #(.DATA_W(DATA_W), .NREG(NREG), .ADDR_W(ADDR_W)) dut (
    .clock   (clock),
    .reset   (reset),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata),
    .raddr1  (raddr1),
    .raddr2  (raddr2),
    .rdata1  (rdata1),
    .rdata2  (rdata2),
    .work_q  (work_q),
    .ctx_cmd (ctx_cmd),
    .ctx_busy(ctx_busy),
    .ctx_done(ctx_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: plain arrays plus "operation in progress / copies done"
  logic [7:0] mReg    [0:NREG];
  logic [7:0] mShadow [0:NREG];
  int         mOp;
  int         mCopies;
  logic [7:0] expR1;
  logic [7:0] expR2;
  logic       expDone;

  int nChecks;
  int nPass;
  int nFail;
  int busyCount;
  int doneCount;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    nChecks++;
    assert (obs === exp) nPass++;
    else begin
      nFail++;
      $error("[TB] FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic checkOutput();
    chk("rdata1", rdata1, expR1);
    chk("rdata2", rdata2, expR2);
    chk("work_q", work_q, mReg[NREG]);
    chk("ctx_busy", {7'd0, ctx_busy}, {7'd0, mOp != 0});
    chk("ctx_done", {7'd0, ctx_done}, {7'd0, expDone});
    if (ctx_busy) busyCount++;
    if (ctx_done) doneCount++;
  endtask

  // Drive one cycle of inputs, advance the model across the edge, then check
  task automatic applyStimulus(input logic rst, input logic iWe, input int iWa,
                               input logic [7:0] iWd, input int iR1, input int iR2,
                               input int iCmd);
    logic wOk;
    reset   = rst;
    we      = iWe;
    waddr   = ADDR_W'(iWa);
    wdata   = iWd;
    raddr1  = ADDR_W'(iR1);
    raddr2  = ADDR_W'(iR2);
    ctx_cmd = 2'(iCmd);
    @(posedge clock);
    if (rst) begin
      for (int i = 0; i <= NREG; i++) begin
        mReg[i]    = 8'h00;
        mShadow[i] = 8'h00;
      end
      mOp     = 0;
      mCopies = 0;
      expR1   = 8'h00;
      expR2   = 8'h00;
      expDone = 1'b0;
    end else begin
      wOk     = iWe && (mOp == 0) && (iWa <= NREG);
      expR1   = (wOk && iWa == iR1) ? iWd : ((iR1 <= NREG) ? mReg[iR1] : 8'h00);
      expR2   = (wOk && iWa == iR2) ? iWd : ((iR2 <= NREG) ? mReg[iR2] : 8'h00);
      expDone = 1'b0;
      if (mOp == 0) begin
        if (wOk) mReg[iWa] = iWd;
        if (iCmd == 1) mOp = 1;
        else if (iCmd == 2) mOp = 2;
        mCopies = 0;
      end else begin
        if (mOp == 1) mShadow[mCopies] = mReg[mCopies];
        else mReg[mCopies] = mShadow[mCopies];
        mCopies++;
        if (mCopies == NREG + 1) begin
          mOp     = 0;
          expDone = 1'b1;
        end
      end
    end
    #1;
    checkOutput();
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 0, 8'h00, i % 8, (i + 4) % 8, 0);
  endtask

  initial begin
    nChecks = 0;
    nPass   = 0;
    nFail   = 0;
    reset   = 1'b1;
    we      = 1'b0;
    waddr   = '0;
    wdata   = '0;
    raddr1  = '0;
    raddr2  = '0;
    ctx_cmd = 2'b00;
    mOp     = 0;
    mCopies = 0;

    // Reset, then read every address
    applyStimulus(1'b1, 1'b0, 0, 8'h00, 0, 0, 0);
    for (int a = 0; a < 4; a++) applyStimulus(1'b0, 1'b0, 0, 8'h00, a, a + 4, 0);
    applyStimulus(1'b0, 1'b0, 0, 8'h00, 0, 0, 0);

    // Bypass on R2, ignored write to address 6
    applyStimulus(1'b0, 1'b1, 2, 8'hA5, 2, 0, 0);
    chk("bypassR2", rdata1, 8'hA5);
    applyStimulus(1'b0, 1'b1, 6, 8'h11, 6, 2, 0);
    applyStimulus(1'b0, 1'b0, 0, 8'h00, 6, 6, 0);
    chk("addr6Ignored", rdata1, 8'h00);

    // Load registers, save, clobber, restore
    for (int r = 0; r < NREG; r++) applyStimulus(1'b0, 1'b1, r, 8'(r + 1), r, 0, 0);
    applyStimulus(1'b0, 1'b1, NREG, 8'h55, 0, 0, 0);
    busyCount = 0;
    doneCount = 0;
    applyStimulus(1'b0, 1'b0, 0, 8'h00, 0, 0, 1);
    idleCycles(6);
    chk("saveBusyLen", 8'(busyCount), 8'd5);
    chk("saveDonePulses", 8'(doneCount), 8'd1);
    for (int r = 0; r <= NREG; r++) applyStimulus(1'b0, 1'b1, r, 8'hFF, r, 0, 0);
    applyStimulus(1'b0, 1'b0, 0, 8'h00, 0, 0, 2);
    idleCycles(6);
    for (int r = 0; r < NREG; r++) begin
      applyStimulus(1'b0, 1'b0, 0, 8'h00, r, NREG, 0);
      chk("restoredReg", rdata1, 8'(r + 1));
    end
    chk("restoredWork", work_q, 8'h55);

    // Write on the acceptance edge is saved; writes while busy are dropped
    applyStimulus(1'b0, 1'b1, 1, 8'h3C, 1, 0, 1);
    applyStimulus(1'b0, 1'b1, 0, 8'h99, 0, 1, 0);
    idleCycles(6);
    applyStimulus(1'b0, 1'b0, 0, 8'h00, 0, 0, 0);
    chk("droppedWriteR0", rdata1, 8'h01);
    applyStimulus(1'b0, 1'b1, 1, 8'h00, 0, 0, 0);
    applyStimulus(1'b0, 1'b0, 0, 8'h00, 0, 0, 2);
    idleCycles(6);
    applyStimulus(1'b0, 1'b0, 0, 8'h00, 1, 0, 0);
    chk("restoredR1", rdata1, 8'h3C);

    // Save request during a restore is ignored; reserved command does nothing
    doneCount = 0;
    applyStimulus(1'b0, 1'b0, 0, 8'h00, 0, 0, 2);
    applyStimulus(1'b0, 1'b0, 0, 8'h00, 0, 0, 1);
    idleCycles(10);
    chk("singleDone", 8'(doneCount), 8'd1);
    applyStimulus(1'b0, 1'b0, 0, 8'h00, 0, 0, 3);
    chk("reservedNoBusy", {7'd0, ctx_busy}, 8'd0);

    // Reset on the third cycle of a save, then restore loads zeros
    applyStimulus(1'b0, 1'b0, 0, 8'h00, 0, 0, 1);
    idleCycles(2);
    applyStimulus(1'b1, 1'b0, 0, 8'h00, 0, 0, 0);
    chk("abortBusy", {7'd0, ctx_busy}, 8'd0);
    chk("abortDone", {7'd0, ctx_done}, 8'd0);
    idleCycles(2);
    applyStimulus(1'b0, 1'b0, 0, 8'h00, 0, 0, 2);
    idleCycles(6);
    applyStimulus(1'b0, 1'b0, 0, 8'h00, 3, NREG, 0);
    chk("zeroRestore", rdata1, 8'h00);

    // Random traffic against the model
    for (int n = 0; n < 600; n++) begin
      int c;
      c = $urandom_range(0, 9);
      applyStimulus(($urandom_range(0, 79) == 0), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 7), 8'($urandom), $urandom_range(0, 7),
                    $urandom_range(0, 7), (c < 7) ? 0 : c - 6);
    end

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
